sli_reset_sequencer: RTL

Generates the sequenced active-low nreset that drives the sli clock/reset VIP interface from a single clock domain. It holds nreset low for a programmable number of cycles and waits a settle period before declaring the DUT ready. In the ready state it accepts software-requested resets through a req/ack handshake. It also reports busy/done status and a saturating count of requested resets.

---
 rtl/sli_reset_sequencer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/sli_reset_sequencer.sv
// Sequenced active-low reset generator for the sli clock/reset interface.
// Power-on and software-requested resets run ASSERT -> SETTLE -> READY.
module sli_reset_sequencer #(
    parameter int ASSERT_CYCLES = 16,
    parameter int SETTLE_CYCLES = 8,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rst_req,
    input  logic [CNT_W-1:0] rst_len,
    output logic             nreset_out,
    output logic             rst_busy,
    output logic             rst_done,
    output logic             rst_req_ack,
    output logic [7:0]       rst_count
);

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("sli_reset_sequencer: CNT_W must be >= 1");
    end
    if (ASSERT_CYCLES < 1) begin : g_bad_assert
        $error("sli_reset_sequencer: ASSERT_CYCLES must be >= 1");
    end
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("sli_reset_sequencer: SETTLE_CYCLES must be >= 1");
    end
    if ((CNT_W < 31) && (ASSERT_CYCLES >= (1 << CNT_W))) begin : g_bad_assert_w
        $error("sli_reset_sequencer: ASSERT_CYCLES does not fit CNT_W");
    end
    if ((CNT_W < 31) && (SETTLE_CYCLES >= (1 << CNT_W))) begin : g_bad_settle_w
        $error("sli_reset_sequencer: SETTLE_CYCLES does not fit CNT_W");
    end

    typedef enum logic [1:0] {
        ST_ASSERT = 2'd0,
        ST_SETTLE = 2'd1,
        ST_READY  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LP_ASSERT_LEN  = CNT_W'(ASSERT_CYCLES);
    localparam logic [CNT_W-1:0] LP_SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LP_CNT_ONE     = CNT_W'(1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_len;
    logic             r_nreset;
    logic             r_busy;
    logic             r_done;
    logic             r_ack;
    logic [7:0]       r_count;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_len_nxt;
    logic             w_nreset_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_ack_nxt;
    logic [7:0]       w_count_nxt;
    logic [CNT_W-1:0] w_len_m1;

    // r_len is never zero, so len-1 cannot wrap and cnt stops at len-1.
    assign w_len_m1 = r_len - LP_CNT_ONE;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_ASSERT;
            r_cnt    <= '0;
            r_len    <= LP_ASSERT_LEN;
            r_nreset <= 1'b0;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
            r_ack    <= 1'b0;
            r_count  <= 8'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_len    <= w_len_nxt;
            r_nreset <= w_nreset_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_ack    <= w_ack_nxt;
            r_count  <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_len_nxt    = r_len;
        w_nreset_nxt = r_nreset;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        w_ack_nxt    = 1'b0;
        w_count_nxt  = r_count;
        unique case (r_state)
            ST_ASSERT: begin
                w_nreset_nxt = 1'b0;
                w_busy_nxt   = 1'b1;
                if (r_cnt == w_len_m1) begin
                    w_state_nxt  = ST_SETTLE;
                    w_cnt_nxt    = '0;
                    w_nreset_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + LP_CNT_ONE;
                end
            end
            ST_SETTLE: begin
                w_nreset_nxt = 1'b1;
                w_busy_nxt   = 1'b1;
                if (r_cnt == LP_SETTLE_LAST) begin
                    w_state_nxt = ST_READY;
                    w_cnt_nxt   = '0;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + LP_CNT_ONE;
                end
            end
            ST_READY: begin
                w_nreset_nxt = 1'b1;
                w_busy_nxt   = 1'b0;
                if (rst_req) begin
                    w_state_nxt  = ST_ASSERT;
                    w_cnt_nxt    = '0;
                    w_nreset_nxt = 1'b0;
                    w_busy_nxt   = 1'b1;
                    w_ack_nxt    = 1'b1;
                    w_len_nxt    = (rst_len == '0) ? LP_ASSERT_LEN : rst_len;
                    w_count_nxt  = (r_count == 8'hFF) ? r_count
                                                      : r_count + 8'd1;
                end
            end
            default: begin
                w_state_nxt  = ST_ASSERT;
                w_cnt_nxt    = '0;
                w_len_nxt    = LP_ASSERT_LEN;
                w_nreset_nxt = 1'b0;
                w_busy_nxt   = 1'b1;
            end
        endcase
    end

    assign nreset_out  = r_nreset;
    assign rst_busy    = r_busy;
    assign rst_done    = r_done;
    assign rst_req_ack = r_ack;
    assign rst_count   = r_count;

endmodule
